// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
//   gp_t              : per-bit / per-group generate-propagate pair
//   NGROUPS           : group count for the default configuration
//   lookahead_carries : flattened lookahead carry vector used at both the
//                       intra-group and the inter-group level
package cla_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_GROUP = 4;
  localparam int unsigned NGROUPS   = DEF_WIDTH / DEF_GROUP;

  // Widest generate/propagate vector the helper accepts.
  localparam int unsigned LA_MAX = 32;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Returns c[0..n]: c[0] = cin, c[k+1] = G[k] | P[k]&c[k], but each carry
  // is expanded to its own sum-of-products so no carry depends on another.
  // Bits above n are zero.
  function automatic logic [LA_MAX:0] lookahead_carries(
    input logic [LA_MAX-1:0] g,
    input logic [LA_MAX-1:0] p,
    input logic              cin,
    input int unsigned       n
  );
    logic [LA_MAX:0]   c;
    logic [LA_MAX-1:0] gs;
    logic [LA_MAX-1:0] ps;
    logic              acc;
    logic              prod;
    c = '0;
    c[0] = cin;
    for (int unsigned k = 0; k < n; k++) begin
      acc  = 1'b0;
      prod = 1'b1;
      // Walk from bit k down to bit 0, accumulating the propagate product.
      for (int unsigned i = 0; i <= k; i++) begin
        gs   = g >> (k - i);
        ps   = p >> (k - i);
        acc  = acc | (gs[0] & prod);
        prod = prod & ps[0];
      end
      acc = acc | (cin & prod);
      c   = c | ({{LA_MAX{1'b0}}, acc} << (k + 1));
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_group.sv
// One first-level lookahead group (combinational).
//   g, p     : per-bit generate / propagate of this group
//   cin      : carry into the group's lowest bit
//   carries  : carry into each bit of the group (carries[0] = cin)
//   group_g  : group generate (carry out with cin = 0)
//   group_p  : group propagate (all bits propagate)
module cla_group_lookahead
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] g,
  input  logic [GROUP-1:0] p,
  input  logic             cin,
  output logic [GROUP-1:0] carries,
  output logic             group_g,
  output logic             group_p
);

  logic [LA_MAX-1:0] g_ext;
  logic [LA_MAX-1:0] p_ext;
  logic [LA_MAX:0]   c_cin;
  logic [LA_MAX:0]   c_zero;
  logic              unused_la;

  always_comb begin
    g_ext  = LA_MAX'(g);
    p_ext  = LA_MAX'(p);
    c_cin  = lookahead_carries(g_ext, p_ext, cin, GROUP);
    c_zero = lookahead_carries(g_ext, p_ext, 1'b0, GROUP);
  end

  assign carries = c_cin[GROUP-1:0];
  assign group_g = c_zero[GROUP];
  assign group_p = &p;

  assign unused_la = ^{c_cin[LA_MAX:GROUP], c_zero[LA_MAX:GROUP+1], c_zero[GROUP-1:0]};

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (a, b, carry_in, sub)
//   out_valid/out_ready  : result handshake (sum, carry_out, overflow, zero)
// Stage 1 registers per-bit g/p and per-group G/P; stage 2 resolves group
// carries by second-level lookahead, then intra-group carries, and registers
// the sum with its flags. Two beats of buffering, full throughput.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NUM_GROUPS = WIDTH / GROUP;

  if (WIDTH % GROUP != 0) begin : g_width_check
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP");
  end
  if (GROUP < 2 || GROUP > 8) begin : g_group_check
    $error("cla_adder_pipe: GROUP must be in 2..8");
  end
  if (NUM_GROUPS >= LA_MAX) begin : g_ngroups_check
    $error("cla_adder_pipe: too many groups for lookahead helper");
  end

  // Stage 1 combinational
  logic [WIDTH-1:0]      b_eff;
  logic [WIDTH-1:0]      in_g;
  logic [WIDTH-1:0]      in_p;
  gp_t  [WIDTH-1:0]      in_bit;
  logic [NUM_GROUPS-1:0] in_grp_g;
  logic [NUM_GROUPS-1:0] in_grp_p;
  gp_t  [NUM_GROUPS-1:0] in_grp;
  logic [WIDTH-1:0]      s1_carries_unused;

  // Stage 1 register
  logic                  s1_valid;
  logic                  s1_cin;
  gp_t  [WIDTH-1:0]      s1_bit;
  gp_t  [NUM_GROUPS-1:0] s1_grp;

  // Stage 2 combinational
  logic [WIDTH-1:0]      s1_g;
  logic [WIDTH-1:0]      s1_p;
  logic [NUM_GROUPS-1:0] s1_grp_g;
  logic [NUM_GROUPS-1:0] s1_grp_p;
  logic [LA_MAX-1:0]     grp_g_ext;
  logic [LA_MAX-1:0]     grp_p_ext;
  logic [LA_MAX:0]       grp_c;
  logic                  unused_grp_c;
  logic [WIDTH-1:0]      bit_c;
  logic [NUM_GROUPS-1:0] s2_grp_g_unused;
  logic [NUM_GROUPS-1:0] s2_grp_p_unused;
  logic [WIDTH-1:0]      next_sum;
  logic                  next_cout;
  logic                  next_ovf;

  // Handshake
  logic s2_free;
  logic s1_move;
  logic accept;

  assign s2_free  = !out_valid || out_ready;
  assign s1_move  = s1_valid && s2_free;
  assign in_ready = !s1_valid || s1_move;
  assign accept   = in_valid && in_ready;

  assign b_eff = sub ? ~b : b;
  assign in_g  = a & b_eff;
  assign in_p  = a ^ b_eff;

  for (genvar bi = 0; bi < WIDTH; bi++) begin : g_bit
    assign in_bit[bi].g = in_g[bi];
    assign in_bit[bi].p = in_p[bi];
    assign s1_g[bi]     = s1_bit[bi].g;
    assign s1_p[bi]     = s1_bit[bi].p;
  end

  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
    // Stage 1 use: only group G/P are needed, carries are left dangling.
    cla_group_lookahead #(.GROUP(GROUP)) u_s1_la (
      .g       (in_g[gi*GROUP +: GROUP]),
      .p       (in_p[gi*GROUP +: GROUP]),
      .cin     (1'b0),
      .carries (s1_carries_unused[gi*GROUP +: GROUP]),
      .group_g (in_grp_g[gi]),
      .group_p (in_grp_p[gi])
    );

    assign in_grp[gi].g = in_grp_g[gi];
    assign in_grp[gi].p = in_grp_p[gi];
    assign s1_grp_g[gi] = s1_grp[gi].g;
    assign s1_grp_p[gi] = s1_grp[gi].p;

    // Stage 2 use: intra-group carries from the resolved group carry-in.
    cla_group_lookahead #(.GROUP(GROUP)) u_s2_la (
      .g       (s1_g[gi*GROUP +: GROUP]),
      .p       (s1_p[gi*GROUP +: GROUP]),
      .cin     (grp_c[gi]),
      .carries (bit_c[gi*GROUP +: GROUP]),
      .group_g (s2_grp_g_unused[gi]),
      .group_p (s2_grp_p_unused[gi])
    );
  end

  always_comb begin
    grp_g_ext = LA_MAX'(s1_grp_g);
    grp_p_ext = LA_MAX'(s1_grp_p);
    grp_c     = lookahead_carries(grp_g_ext, grp_p_ext, s1_cin, NUM_GROUPS);
  end

  assign unused_grp_c = ^grp_c[LA_MAX:NUM_GROUPS+1];

  assign next_sum  = s1_p ^ bit_c;
  assign next_cout = grp_c[NUM_GROUPS];
  assign next_ovf  = bit_c[WIDTH-1] ^ grp_c[NUM_GROUPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_cin    <= 1'b0;
      s1_bit    <= '0;
      s1_grp    <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (accept) begin
        s1_bit <= in_bit;
        s1_grp <= in_grp;
        s1_cin <= carry_in;
      end
      if (s2_free) begin
        out_valid <= s1_valid;
      end
      if (s1_move) begin
        sum       <= next_sum;
        carry_out <= next_cout;
        overflow  <= next_ovf;
        zero      <= (next_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
module tb_cla_adder_pipe;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;
  bit   rand_ready = 1'b0;
  exp_t sb[$];

  cla_adder_pipe #(.WIDTH(16), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops expected results and checks output stability under stall.
  bit   held_valid = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur = {sum, carry_out, overflow, zero};
    if (rst) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        checks++;
        if (out_valid !== 1'b1 || cur !== held) begin
          failures++;
          $display("FAIL hold_stable actual=%h/%b required=%h/1", cur, out_valid, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", cur);
        end else begin
          e = sb.pop_front();
          if (cur !== e) begin
            failures++;
            $display("FAIL result actual sum=%h c=%b v=%b z=%b required sum=%h c=%b v=%b z=%b",
                     cur.sum, cur.cout, cur.ovf, cur.zero, e.sum, e.cout, e.ovf, e.zero);
          end
        end
      end
      held_valid = out_valid && !out_ready;
      held       = cur;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                      input logic ts, input logic tc, input exp_t e);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    sub      = ts;
    carry_in = tc;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic ts, input logic tc);
    logic [15:0] be;
    logic [16:0] full;
    exp_t        e;
    be     = ts ? ~tb : tb;
    full   = {1'b0, ta} + {1'b0, be} + {16'b0, tc};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (ta[15] == be[15]) && (full[15] != ta[15]);
    e.zero = (full[15:0] == 16'h0000);
    return e;
  endfunction

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic        rc;
    int          p0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 16'h0000);
    check("rst_flags", {carry_out, overflow, zero}, 3'b000);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Full carry propagation, overflow boundaries, subtract, carry_in
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0});
    send(16'h8000, 16'h0001, 1'b1, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0});
    send(16'h1234, 16'h1234, 1'b1, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1});
    send(16'h0000, 16'h0001, 1'b1, 1'b1, {16'hFFFF, 1'b0, 1'b0, 1'b0});
    send(16'h00FF, 16'h0000, 1'b0, 1'b1, {16'h0100, 1'b0, 1'b0, 1'b0});
    drain();

    // Backpressure: two beats fill the pipe, then release
    out_ready = 1'b0;
    send(16'h0001, 16'h0001, 1'b0, 1'b0, {16'h0002, 1'b0, 1'b0, 1'b0});
    send(16'h0002, 16'h0002, 1'b0, 1'b0, {16'h0004, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("stall_sum", sum, 16'h0002);
    repeat (2) @(negedge clk);
    check("full_in_ready_late", in_ready, 0);
    check("stall_sum_late", sum, 16'h0002);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    p0 = pops;
    fork
      begin
        send(16'h0003, 16'h0003, 1'b0, 1'b0, {16'h0006, 1'b0, 1'b0, 1'b0});
        send(16'h0004, 16'h0004, 1'b0, 1'b0, {16'h0008, 1'b0, 1'b0, 1'b0});
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        check("release_rate", pops - p0, 4);
      end
    join
    drain();

    // Reset with two beats in flight
    send(16'h0011, 16'h0022, 1'b0, 1'b0, {16'h0033, 1'b0, 1'b0, 1'b0});
    send(16'h0100, 16'h0200, 1'b0, 1'b0, {16'h0300, 1'b0, 1'b0, 1'b0});
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(16'h1000, 16'h0F00, 1'b0, 1'b0, {16'h1F00, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    check("latency_early", out_valid, 0);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    @(posedge clk);
    #1;
    drain();

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rs, rc, model(ra, rb, rs, rc));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
